// File: rtl/mixed_param_pkg.sv
// mixed_param_pkg: shared types and default widths for the request queue slice
//   state_e  : issue FSM states
//   DATA_W / ADDR_W : default request data / address widths
//   STATUS_W : downstream status width, CNT_W : issued-beat counter width
package mixed_param_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, HALT} state_e;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 12;
    localparam int STATUS_W = 4;
    localparam int CNT_W    = 16;
endpackage

// File: rtl/mixed_param_sync_fifo.sv
// mixed_param_sync_fifo: synchronous FIFO with registered storage and push/pop/flush
//   clk, rst           : clock, asynchronous active-high reset
//   push_i / din_i     : write strobe and data (ignored when full or flushing)
//   pop_i / dout_o     : read strobe and head entry (ignored when empty or flushing)
//   flush_i            : empties the FIFO, dropping any same-cycle push
//   full_o / empty_o / level_o : occupancy flags and count
module mixed_param_sync_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [LVL_W-1:0] level_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             push_ok, pop_ok;

    assign full_o  = lvl_q == LVL_W'(DEPTH);
    assign empty_o = lvl_q == '0;
    assign level_o = lvl_q;
    // Head entry is read straight from storage: an entry written at one edge is
    // visible the next cycle and stays put until popped, since a full FIFO never
    // accepts a write that could overwrite the head.
    assign dout_o  = mem_q[rd_q];
    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_d  = flush_i ? '0 : wr_q + PTR_W'(push_ok);
        rd_d  = flush_i ? '0 : rd_q + PTR_W'(pop_ok);
        lvl_d = flush_i ? '0 : lvl_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    // Storage is cleared on reset so the head reads as zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_ok) begin
            mem_q[wr_q] <= din_i;
        end
    end
endmodule

// File: rtl/mixed_param_req_queue.sv
// mixed_param_req_queue: buffers host write requests and issues them downstream, halting on error status
//   clk, reset                      : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_addr : host request push interface
//   out_enable/out_data/out_addr/ready : downstream beat handshake
//   status                          : downstream status, nonzero halts issue
//   err_clear / flush               : leave HALT / discard buffered requests
//   halted/err_code/level/issued_count : observability
module mixed_param_req_queue
    import mixed_param_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int FIFO_DEPTH = 8,
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    output logic                  out_enable,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    input  logic                  ready,
    input  logic [STATUS_W-1:0]   status,
    input  logic                  err_clear,
    input  logic                  flush,
    output logic                  halted,
    output logic [STATUS_W-1:0]   err_code,
    output logic [LVL_W-1:0]      level,
    output logic [CNT_W-1:0]      issued_count
);
    state_e                          state_q, state_d;
    logic [STATUS_W-1:0]             err_q, err_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            full, empty, push_acc, beat_done;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

    mixed_param_sync_fifo #(
        .WIDTH(ADDR_WIDTH + DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (reset),
        .push_i (in_valid),
        .pop_i  (beat_done),
        .flush_i(flush),
        .din_i  ({in_addr, in_data}),
        .dout_o (head),
        .full_o (full),
        .empty_o(empty),
        .level_o(level)
    );

    assign in_ready              = !full;
    assign push_acc              = in_valid && !full && !flush;
    // Built from registered state only, so reset drops it without a clock edge.
    assign out_enable            = state_q == ISSUE && !empty;
    assign beat_done             = out_enable && ready;
    assign {out_addr, out_data}  = head;
    assign halted                = state_q == HALT;
    assign err_code              = err_q;
    assign issued_count          = cnt_q;

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        cnt_d   = cnt_q + CNT_W'(beat_done);
        case (state_q)
            // Leaving IDLE on the accepting edge gives one-cycle push-to-issue latency.
            IDLE:  state_d = (!flush && (!empty || push_acc)) ? ISSUE : IDLE;
            // A beat completing alongside an error still pops and counts above.
            ISSUE: begin
                if (status != '0) begin
                    state_d = HALT;
                    err_d   = status;
                end else if (flush || (empty && !push_acc)) begin
                    state_d = IDLE;
                end
            end
            HALT:  state_d = err_clear ? IDLE : HALT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            err_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_mixed_param_req_queue.sv
// tb_mixed_param_req_queue: directed self-checking bench for mixed_param_req_queue
module tb_mixed_param_req_queue;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [11:0] in_addr = '0;
    logic        out_enable;
    logic [15:0] out_data;
    logic [11:0] out_addr;
    logic        ready = 1'b0;
    logic [3:0]  status = '0;
    logic        err_clear = 1'b0;
    logic        flush = 1'b0;
    logic        halted;
    logic [3:0]  err_code;
    logic [3:0]  level;
    logic [15:0] issued_count;
    int          checks = 0;
    int          errors = 0;

    mixed_param_req_queue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr), .out_enable(out_enable),
        .out_data(out_data), .out_addr(out_addr), .ready(ready), .status(status),
        .err_clear(err_clear), .flush(flush), .halted(halted), .err_code(err_code),
        .level(level), .issued_count(issued_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0h exp 1", in_ready); end
        checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL reset_out_enable got %0h exp 0", out_enable); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data got %0h exp 0", out_data); end
        checks++; if (out_addr !== 12'h0) begin errors++; $display("FAIL reset_out_addr got %0h exp 0", out_addr); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0h exp 0", halted); end
        checks++; if (err_code !== 4'h0) begin errors++; $display("FAIL reset_err_code got %0h exp 0", err_code); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
        checks++; if (issued_count !== 16'h0) begin errors++; $display("FAIL reset_issued got %0h exp 0", issued_count); end
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    task automatic test_basic;
        tick;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_addr  = 12'h010 + 12'(i);
            in_data  = 16'hA000 + 16'(i);
            tick;
            checks++; if (out_enable !== 1'b1) begin errors++; $display("FAIL basic_en%0d got %0h exp 1", i, out_enable); end
            checks++; if (out_data !== 16'hA000 + 16'(i)) begin errors++; $display("FAIL basic_data%0d got %0h exp %0h", i, out_data, 16'hA000 + 16'(i)); end
            checks++; if (out_addr !== 12'h010 + 12'(i)) begin errors++; $display("FAIL basic_addr%0d got %0h exp %0h", i, out_addr, 12'h010 + 12'(i)); end
            checks++; if (issued_count !== 16'(i)) begin errors++; $display("FAIL basic_cnt%0d got %0d exp %0d", i, issued_count, i); end
        end
        in_valid = 1'b0;
        tick;
        checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL basic_drain_en got %0h exp 0", out_enable); end
        checks++; if (level !== 4'd0) begin errors++; $display("FAIL basic_drain_level got %0d exp 0", level); end
        checks++; if (issued_count !== 16'd3) begin errors++; $display("FAIL basic_issued got %0d exp 3", issued_count); end
        tick;
        checks++; if (out_enable !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL basic_idle got en=%0h halted=%0h exp 0/0", out_enable, halted); end
    endtask

    task automatic test_backpressure;
        ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_addr  = 12'h100 + 12'(i);
            in_data  = 16'hB000 + 16'(i);
            tick;
            checks++; if (level !== 4'(i + 1)) begin errors++; $display("FAIL bp_level%0d got %0d exp %0d", i, level, i + 1); end
            checks++; if (out_data !== 16'hB000 || out_addr !== 12'h100) begin errors++; $display("FAIL bp_stable%0d got %0h/%0h exp 100/b000", i, out_addr, out_data); end
        end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %0h exp 0", in_ready); end
        in_addr = 12'hFFF;
        in_data = 16'hDEAD;
        tick;
        checks++; if (level !== 4'd8) begin errors++; $display("FAIL bp_ninth got %0d exp 8", level); end
        checks++; if (out_enable !== 1'b1 || out_data !== 16'hB000) begin errors++; $display("FAIL bp_hold got en=%0h data=%0h exp 1/b000", out_enable, out_data); end
    endtask

    task automatic test_full_push_pop;
        ready = 1'b1;
        tick;
        in_valid = 1'b0;
        checks++; if (level !== 4'd7) begin errors++; $display("FAIL fpp_level got %0d exp 7", level); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fpp_in_ready got %0h exp 1", in_ready); end
        for (int i = 1; i < 8; i++) begin
            checks++; if (out_data !== 16'hB000 + 16'(i) || out_addr !== 12'h100 + 12'(i)) begin errors++; $display("FAIL fpp_order%0d got %0h/%0h exp %0h/%0h", i, out_addr, out_data, 12'h100 + 12'(i), 16'hB000 + 16'(i)); end
            tick;
        end
        checks++; if (level !== 4'd0 || out_enable !== 1'b0) begin errors++; $display("FAIL fpp_empty got level=%0d en=%0h exp 0/0", level, out_enable); end
        checks++; if (issued_count !== 16'd11) begin errors++; $display("FAIL fpp_issued got %0d exp 11", issued_count); end
        tick;
    endtask

    task automatic test_halt;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_addr  = 12'h020 + 12'(i);
            in_data  = 16'hC000 + 16'(i);
            tick;
        end
        in_valid = 1'b0;
        checks++; if (level !== 4'd4 || out_addr !== 12'h020) begin errors++; $display("FAIL halt_pre got level=%0d addr=%0h exp 4/020", level, out_addr); end
        status = 4'h5;
        ready  = 1'b1;
        tick;
        checks++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_halted got %0h exp 1", halted); end
        checks++; if (err_code !== 4'h5) begin errors++; $display("FAIL halt_err_code got %0h exp 5", err_code); end
        checks++; if (out_enable !== 1'b0) begin errors++; $display("FAIL halt_en got %0h exp 0", out_enable); end
        checks++; if (level !== 4'd3 || issued_count !== 16'd12) begin errors++; $display("FAIL halt_counted got level=%0d cnt=%0d exp 3/12", level, issued_count); end
        status = 4'h3;
        tick;
        checks++; if (err_code !== 4'h5 || level !== 4'd3 || halted !== 1'b1) begin errors++; $display("FAIL halt_ignore got err=%0h level=%0d halted=%0h exp 5/3/1", err_code, level, halted); end
        status   = 4'h0;
        in_valid = 1'b1;
        in_addr  = 12'h024;
        in_data  = 16'hC004;
        tick;
        in_valid = 1'b0;
        checks++; if (level !== 4'd4 || halted !== 1'b1) begin errors++; $display("FAIL halt_push got level=%0d halted=%0h exp 4/1", level, halted); end
        err_clear = 1'b1;
        tick;
        err_clear = 1'b0;
        checks++; if (halted !== 1'b0 || out_enable !== 1'b0 || err_code !== 4'h5) begin errors++; $display("FAIL halt_clear got halted=%0h en=%0h err=%0h exp 0/0/5", halted, out_enable, err_code); end
        tick;
        ready = 1'b0;
        checks++; if (out_enable !== 1'b1 || out_addr !== 12'h021 || out_data !== 16'hC001) begin errors++; $display("FAIL halt_resume got en=%0h %0h/%0h exp 1 021/c001", out_enable, out_addr, out_data); end
    endtask

    task automatic test_flush;
        in_valid = 1'b1;
        in_addr  = 12'h025;
        in_data  = 16'hC005;
        tick;
        checks++; if (level !== 4'd5) begin errors++; $display("FAIL flush_pre got %0d exp 5", level); end
        in_addr = 12'h0AA;
        in_data = 16'h00AA;
        flush   = 1'b1;
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        checks++; if (level !== 4'd0 || out_enable !== 1'b0) begin errors++; $display("FAIL flush_clear got level=%0d en=%0h exp 0/0", level, out_enable); end
        checks++; if (issued_count !== 16'd12 || halted !== 1'b0) begin errors++; $display("FAIL flush_cnt got cnt=%0d halted=%0h exp 12/0", issued_count, halted); end
        tick;
        checks++; if (level !== 4'd0 || out_enable !== 1'b0) begin errors++; $display("FAIL flush_idle got level=%0d en=%0h exp 0/0", level, out_enable); end
    endtask

    task automatic test_async_reset;
        ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_addr  = 12'h030 + 12'(i);
            in_data  = 16'hD000 + 16'(i);
            tick;
        end
        in_valid = 1'b0;
        checks++; if (level !== 4'd4 || out_enable !== 1'b1) begin errors++; $display("FAIL arst_pre got level=%0d en=%0h exp 4/1", level, out_enable); end
        #2 reset = 1'b1;
        #1;
        checks++; if (level !== 4'd0 || out_enable !== 1'b0) begin errors++; $display("FAIL arst_now got level=%0d en=%0h exp 0/0", level, out_enable); end
        checks++; if (out_data !== 16'h0 || out_addr !== 12'h0) begin errors++; $display("FAIL arst_out got %0h/%0h exp 0/0", out_addr, out_data); end
        checks++; if (issued_count !== 16'h0 || err_code !== 4'h0 || in_ready !== 1'b1) begin errors++; $display("FAIL arst_misc got cnt=%0d err=%0h in_ready=%0h exp 0/0/1", issued_count, err_code, in_ready); end
        @(posedge clk);
        #2 reset = 1'b0;
        tick;
        checks++; if (level !== 4'd0 || out_enable !== 1'b0) begin errors++; $display("FAIL arst_after got level=%0d en=%0h exp 0/0", level, out_enable); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_full_push_pop;
        test_halt;
        test_flush;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
